// File: rtl/core_pkg.sv
// Shared types and constants for the core_seq instruction sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_ILLEGAL  = 3'd1,
    CAUSE_EBREAK   = 3'd2,
    CAUSE_MISALIGN = 3'd3,
    CAUSE_TIMEOUT  = 3'd4
  } halt_cause_e;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [31:0] INST_STRIDE = 32'd4;

  // Instructions are word aligned; any low-order address bit set is a bad target.
  function automatic logic target_misaligned(input logic [31:0] target);
    return target[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive un-acknowledged fetch cycles and flags the last allowed one.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Fires during the TIMEOUT-th missed cycle so the FSM can leave on that edge.
  assign expired = tick && (count_q == CW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/WB with halt reporting.
module core_seq
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] inst,
  input  logic        dec_w_en,
  input  logic        dec_illegal,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted,
  output logic [2:0]  halt_cause,
  output logic [31:0] retire_cnt
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] retire_q;
  halt_cause_e cause_q;

  logic wd_clear;
  logic wd_tick;
  logic wd_expired;
  logic wb_misalign;

  assign wb_misalign = branch_taken && target_misaligned(branch_target);
  assign wd_tick     = (state_q == S_FETCH) && !imem_ack;
  assign wd_clear    = (state_q != S_FETCH) || imem_ack;

  fetch_watchdog #(
    .TIMEOUT (FETCH_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .tick    (wd_tick),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      inst_q   <= '0;
      retire_q <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_FETCH;
        end
        S_FETCH: begin
          // An ack on the final allowed cycle takes precedence over the timeout.
          if (imem_ack) begin
            inst_q  <= imem_rdata;
            state_q <= S_DECODE;
          end else if (wd_expired) begin
            cause_q <= CAUSE_TIMEOUT;
            state_q <= S_HALT;
          end
        end
        S_DECODE: begin
          if (inst_q == EBREAK_INST) begin
            cause_q <= CAUSE_EBREAK;
            state_q <= S_HALT;
          end else if (dec_illegal) begin
            cause_q <= CAUSE_ILLEGAL;
            state_q <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_q <= S_WB;
        end
        S_WB: begin
          if (wb_misalign) begin
            cause_q <= CAUSE_MISALIGN;
            state_q <= S_HALT;
          end else begin
            pc_q     <= branch_taken ? branch_target : pc_q + INST_STRIDE;
            retire_q <= retire_q + 32'd1;
            state_q  <= S_FETCH;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Write strobe is qualified combinationally so a reset or bad branch in WB suppresses it.
  assign rf_we      = (state_q == S_WB) && dec_w_en && !wb_misalign && !rst;
  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign pc         = pc_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted     = (state_q == S_HALT);
  assign halt_cause = cause_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq with a fetch-address scoreboard and a wrap-around instance.
module tb_core_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ack = 1'b0;
  logic        dec_w_en = 1'b0;
  logic        dec_illegal = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;

  logic        imem_req, rf_we, busy, halted;
  logic [31:0] imem_addr, inst, pc, retire_cnt;
  logic [2:0]  halt_cause;

  logic        w_imem_req, w_rf_we, w_busy, w_halted;
  logic [31:0] w_imem_addr, w_inst, w_pc, w_retire_cnt;
  logic [2:0]  w_halt_cause;

  int          errors = 0;
  int          checks = 0;
  int          ack_delay = 0;
  int          fetch_wait = 0;
  int          we_seen = 0;
  logic [31:0] mem_word = 32'h0;
  logic [31:0] exp_addr[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  core_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .inst(inst), .dec_w_en(dec_w_en), .dec_illegal(dec_illegal),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .rf_we(rf_we), .pc(pc), .busy(busy), .halted(halted),
    .halt_cause(halt_cause), .retire_cnt(retire_cnt)
  );

  core_seq #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .inst(w_inst), .dec_w_en(dec_w_en), .dec_illegal(dec_illegal),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .rf_we(w_rf_we), .pc(w_pc), .busy(w_busy), .halted(w_halted),
    .halt_cause(w_halt_cause), .retire_cnt(w_retire_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard the first cycle of each fetch, then model the memory reply.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rf_we) we_seen++;
    if (imem_req && fetch_wait == 0) begin
      chk("fetch_expected", 32'(exp_addr.size() != 0), 32'd1);
      if (exp_addr.size() != 0) begin
        e = exp_addr.pop_front();
        chk("imem_addr", imem_addr, e);
        $display("fetch addr=%h expected=%h", imem_addr, e);
      end
    end
    if (imem_req) begin
      imem_ack   = (fetch_wait == ack_delay);
      imem_rdata = imem_ack ? mem_word : 32'hDEAD_BEEF;
      fetch_wait++;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      fetch_wait = 0;
    end
  endtask

  task automatic do_reset();
    chk("sb_drained", 32'(exp_addr.size()), 32'd0);
    exp_addr.delete();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_retire", retire_cnt, 32'h0);
    chk("rst_flags", {29'h0, busy, halted, imem_req}, 32'h0);
    chk("rst_cause_we", {28'h0, halt_cause, rf_we}, 32'h0);
    chk("rst_w_pc", w_pc, 32'hFFFF_FFFC);
    chk("rst_w_state", {w_busy, w_halted, w_imem_req, w_rf_we, w_halt_cause, w_inst[23:0]} ^ w_retire_cnt, 32'h0);
    $display("reset pc=%h busy=%b halted=%b", pc, busy, halted);
    rst = 1'b0;
    we_seen = 0;
  endtask

  initial begin
    // Back-to-back addi with single-cycle ack; start held high to show it is ignored.
    do_reset();
    mem_word = 32'h0010_0093; dec_w_en = 1'b1; dec_illegal = 1'b0; branch_taken = 1'b0; ack_delay = 0;
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8); exp_addr.push_back(32'hC);
    start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("rf_we_cadence", rf_we, ((i % 4) == 0));
      if (i == 2) chk("inst_loaded", inst, 32'h0010_0093);
      if (i == 5) begin
        chk("pc_after_1", pc, 32'h4);
        chk("w_pc_wrap", w_pc, 32'h0);
        chk("w_addr_wrap", w_imem_addr, 32'h0);
      end
    end
    tick();
    start = 1'b0;
    chk("retire_3", retire_cnt, 32'd3);
    chk("pc_after_3", pc, 32'hC);
    $display("addi run retire=%0d pc=%h", retire_cnt, pc);

    // Delayed ack: request held 6 cycles, address and inst stable until the ack.
    do_reset();
    mem_word = 32'h0020_0093; ack_delay = 5;
    exp_addr.push_back(32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 2; j <= 6; j++) begin
      tick();
      chk("req_held", imem_req, 1'b1);
      chk("addr_stable", imem_addr, 32'h0);
      chk("inst_before_ack", inst, 32'h0);
    end
    tick();
    chk("req_dropped", imem_req, 1'b0);
    chk("inst_on_ack", inst, 32'h0020_0093);
    $display("delayed ack inst=%h", inst);

    // Aligned branch redirects, then a misaligned one halts without retiring.
    do_reset();
    mem_word = 32'h0010_0093; ack_delay = 0; branch_taken = 1'b1; branch_target = 32'h100;
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h100);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("br_wb_we", rf_we, 1'b1);
    tick();
    chk("br_retire", retire_cnt, 32'd1);
    branch_target = 32'h102;
    tick(); tick(); tick();
    chk("mis_wb_we", rf_we, 1'b0);
    tick();
    chk("mis_halted", halted, 1'b1);
    chk("mis_cause", halt_cause, 3'd3);
    chk("mis_retire", retire_cnt, 32'd1);
    chk("mis_pc", pc, 32'h100);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("halt_absorb", {halted, imem_req, busy}, 3'b100);
    $display("misaligned branch cause=%0d retire=%0d", halt_cause, retire_cnt);
    branch_taken = 1'b0;

    // Ebreak (with illegal also raised, ebreak must win), then a plain illegal opcode.
    do_reset();
    mem_word = 32'h0010_0073; dec_illegal = 1'b1;
    exp_addr.push_back(32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("ebreak_halt", halted, 1'b1);
    chk("ebreak_cause", halt_cause, 3'd2);
    chk("ebreak_no_we", 32'(we_seen), 32'd0);
    $display("ebreak cause=%0d", halt_cause);
    do_reset();
    mem_word = 32'h0010_0093; dec_illegal = 1'b1;
    exp_addr.push_back(32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("illegal_halt", halted, 1'b1);
    chk("illegal_cause", halt_cause, 3'd1);
    chk("illegal_no_we", 32'(we_seen), 32'd0);
    $display("illegal cause=%0d", halt_cause);
    dec_illegal = 1'b0;

    // Fetch watchdog: no ack for 16 cycles halts; ack on the 16th does not.
    do_reset();
    ack_delay = 1000;
    exp_addr.push_back(32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 16; k++) tick();
    chk("wd_not_yet", halted, 1'b0);
    tick();
    chk("wd_halted", halted, 1'b1);
    chk("wd_cause", halt_cause, 3'd4);
    $display("timeout cause=%0d", halt_cause);
    do_reset();
    ack_delay = 15;
    exp_addr.push_back(32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 16; k++) tick();
    tick();
    chk("wd_late_ack_run", {halted, busy}, 2'b01);
    chk("wd_late_ack_inst", inst, 32'h0010_0093);
    $display("late ack halted=%b inst=%h", halted, inst);

    // Reset during WB suppresses the write and the retire.
    do_reset();
    ack_delay = 0; dec_w_en = 1'b1;
    exp_addr.push_back(32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_wb_no_we", rf_we, 1'b0);
    tick();
    chk("rst_wb_idle", {busy, halted}, 2'b00);
    chk("rst_wb_pc", pc, 32'h0);
    chk("rst_wb_retire", retire_cnt, 32'h0);
    chk("rst_wb_w_pc", w_pc, 32'hFFFF_FFFC);
    $display("reset in wb pc=%h retire=%0d", pc, retire_cnt);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: pc value after reset.
REQ-002 Parameter FETCH_TIMEOUT, default 16: max cycles in FETCH awaiting imem_ack before halt.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  begin execution from IDLE.
REQ-007 imem_req  out  1  fetch request.
REQ-008 imem_addr  out  32  fetch address, equals pc.
REQ-009 imem_rdata  in  32  fetched word, valid when imem_ack=1.
REQ-010 imem_ack  in  1  fetch completes this cycle.
REQ-011 inst  out  32  registered instruction driven to decoder.
REQ-012 dec_w_en  in  1  decoder write-enable for current inst.
REQ-013 dec_illegal  in  1  decoder flags unsupported opcode.
REQ-014 branch_taken  in  1  branch unit: redirect pc (sampled in WB).
REQ-015 branch_target  in  32  redirect address.
REQ-016 rf_we  out  1  register-file write strobe.
REQ-017 pc  out  32  current instruction address.
REQ-018 busy  out  1  high in any state except IDLE/HALT.
REQ-019 halted  out  1  high in HALT.
REQ-020 halt_cause  out  3  0 none, 1 illegal, 2 ebreak, 3 misaligned target, 4 fetch timeout.
REQ-021 retire_cnt  out  32  retired-instruction count.

Function
REQ-022 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-023 IDLE: start=1 -> FETCH next cycle; else stay.
REQ-024 FETCH: imem_req=1 and imem_addr=pc every cycle; imem_ack=1 -> inst<=imem_rdata, -> DECODE.
REQ-025 FETCH watchdog: counter cleared on entering FETCH, +1 per cycle without ack; ack absent for FETCH_TIMEOUT consecutive cycles -> HALT, cause 4; ack on the last allowed cycle wins.
REQ-026 DECODE: inst==32'h0010_0073 -> HALT, cause 2; else dec_illegal=1 -> HALT, cause 1; else -> EXEC. Ebreak has priority over illegal.
REQ-027 EXEC: unconditional -> WB (one cycle for ALU settle).
REQ-028 WB: rf_we=dec_w_en for exactly this one cycle; rf_we=0 in all other states.
REQ-029 WB: branch_taken=1 and branch_target[1:0]!=0 -> HALT, cause 3, rf_we forced 0, pc and retire_cnt unchanged.
REQ-030 WB otherwise: pc<=branch_taken ? branch_target : pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); retire_cnt+1 (wraps); -> FETCH.
REQ-031 Latency: 4 cycles per instruction with single-cycle ack (FETCH, DECODE, EXEC, WB).
REQ-032 HALT: absorbing until rst; start ignored; imem_req=0; halt_cause held.
REQ-033 start outside IDLE SHALL be ignored.
REQ-034 inst SHALL change only on FETCH-state ack.

Reset
REQ-035 rst=1 SHALL force next cycle: state IDLE, pc=RESET_PC, inst=0, retire_cnt=0, halt_cause=0, watchdog=0, imem_req=0, rf_we=0, busy=0, halted=0.
REQ-036 rst mid-fetch or mid-WB SHALL abort with no rf_we pulse and no retire increment in that cycle.

Structure
REQ-037 Shared package core_pkg SHALL hold the state enum, halt-cause codes, and EBREAK encoding constant.
REQ-038 Watchdog SHALL be sub-module fetch_watchdog (inputs clear, tick; output expired); remainder inline.

Verification
REQ-039 Reset, start, ack every cycle on 32'h0010_0093 (addi, w_en=1) -> rf_we pulses every 4th cycle, pc 0,4,8, retire_cnt 3 after 12 cycles.
REQ-040 Ack delayed 5 cycles -> imem_req held 6 cycles, imem_addr stable, inst updates only on ack.
REQ-041 branch_taken=1, target 32'h0000_0100 -> next imem_addr 32'h100; target 32'h0000_0102 -> HALT, cause 3, retire_cnt unchanged.
REQ-042 Fetch 32'h0010_0073 -> HALT cause 2; separately dec_illegal=1 -> cause 1; rf_we never asserted.
REQ-043 No ack for 16 cycles -> halted=1, cause 4; ack at 16th cycle -> DECODE, no halt.
REQ-044 rst asserted in WB -> no rf_we, IDLE, pc=RESET_PC; RESET_PC=32'hFFFF_FFFC run -> pc wraps to 0.
